// File: rtl/board_scanner_pkg.sv
// Shared chess constants: square-code piece types, move-side one-hot encodings,
// colours and the scanner FSM state codes.
package board_scanner_pkg;

    localparam int NUM_SQ = 64;
    localparam int CODE_W = 6;
    localparam int IDX_W  = 6;
    localparam int CNT_W  = 5;

    localparam logic [4:0] T_EMPTY  = 5'b00000;
    localparam logic [4:0] T_PAWN   = 5'b00010;
    localparam logic [4:0] T_KNIGHT = 5'b00001;
    localparam logic [4:0] T_KING   = 5'b00100;
    localparam logic [4:0] T_QUEEN  = 5'b11000;
    localparam logic [4:0] T_ROOK   = 5'b10000;
    localparam logic [4:0] T_BISHOP = 5'b01000;

    localparam logic [5:0] OH_PAWN   = 6'b000001;
    localparam logic [5:0] OH_ROOK   = 6'b000010;
    localparam logic [5:0] OH_KNIGHT = 6'b000100;
    localparam logic [5:0] OH_BISHOP = 6'b001000;
    localparam logic [5:0] OH_QUEEN  = 6'b010000;
    localparam logic [5:0] OH_KING   = 6'b100000;

    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

    localparam logic [CODE_W-1:0] EMPTY_CODE = 6'b000000;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Zero for both the empty type and any code that is not a real piece.
    function automatic logic [5:0] type_onehot(input logic [4:0] t);
        logic [5:0] oh;
        case (t)
            T_PAWN:   oh = OH_PAWN;
            T_ROOK:   oh = OH_ROOK;
            T_KNIGHT: oh = OH_KNIGHT;
            T_BISHOP: oh = OH_BISHOP;
            T_QUEEN:  oh = OH_QUEEN;
            T_KING:   oh = OH_KING;
            default:  oh = 6'b000000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/board_scanner_square_decoder.sv
// Combinational decode of one square code into match/empty/illegal flags and
// the move-side one-hot piece type.
module square_decoder
    import board_scanner_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    input  logic              color,
    output logic              match,
    output logic              empty,
    output logic              illegal,
    output logic [5:0]        onehot
);

    logic [5:0] w_onehot;
    logic       w_empty;
    logic       w_illegal;

    assign w_onehot  = type_onehot(code[4:0]);
    // The colour bit is ignored on an empty square.
    assign w_empty   = (code[4:0] == T_EMPTY);
    assign w_illegal = !w_empty && (w_onehot == 6'b000000);

    assign empty   = w_empty;
    assign illegal = w_illegal;
    assign onehot  = w_onehot;
    assign match   = !w_empty && !w_illegal && (code[5] == color);

endmodule

// File: rtl/board_scanner.sv
// Snapshots the 64-square board on start and streams one descriptor per piece
// of the requested colour (one-hot square, one-hot type, index) over valid/ready.
module board_scanner
    import board_scanner_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      clear,
    input  logic                      color_type,
    input  logic [NUM_SQ*CODE_W-1:0]  board_flat,
    output logic                      piece_valid,
    input  logic                      piece_ready,
    output logic [NUM_SQ-1:0]         position_out,
    output logic [5:0]                piece_out,
    output logic [IDX_W-1:0]          square_idx,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          piece_count,
    output logic                      code_err
);

    logic [1:0]                r_state;
    logic [NUM_SQ*CODE_W-1:0]  r_snap;
    logic                      r_color;
    logic [IDX_W-1:0]          r_idx;
    logic [CNT_W-1:0]          r_count;
    logic                      r_err;
    logic                      r_valid;
    logic [NUM_SQ-1:0]         r_pos;
    logic [5:0]                r_piece;
    logic [IDX_W-1:0]          r_sqidx;
    logic                      r_busy;
    logic                      r_done;

    logic [CODE_W-1:0]         w_code;
    logic                      w_match;
    logic                      w_empty;
    logic                      w_illegal;
    logic [5:0]                w_onehot;
    logic                      w_last;
    logic [CNT_W-1:0]          w_count_inc;

    assign w_code      = r_snap[int'(r_idx)*CODE_W +: CODE_W];
    assign w_last      = (r_idx == IDX_W'(NUM_SQ - 1));
    assign w_count_inc = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + 1'b1;

    square_decoder u_dec (
        .code    (w_code),
        .color   (r_color),
        .match   (w_match),
        .empty   (w_empty),
        .illegal (w_illegal),
        .onehot  (w_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_snap  <= '0;
            r_color <= 1'b0;
            r_idx   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
            r_pos   <= '0;
            r_piece <= '0;
            r_sqidx <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (clear) begin
            // Abort keeps the count and error flag of the interrupted scan.
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_pos   <= '0;
            r_piece <= '0;
            r_sqidx <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_snap  <= board_flat;
                        r_color <= color_type;
                        r_idx   <= '0;
                        r_count <= '0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_match) begin
                        r_valid <= 1'b1;
                        r_pos   <= NUM_SQ'(1) << r_idx;
                        r_piece <= w_onehot;
                        r_sqidx <= r_idx;
                        r_state <= S_EMIT;
                    end else begin
                        if (w_illegal)
                            r_err <= 1'b1;
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    // Descriptor stays put until the consumer takes it.
                    if (piece_ready) begin
                        r_valid <= 1'b0;
                        r_pos   <= '0;
                        r_piece <= '0;
                        r_sqidx <= '0;
                        r_count <= w_count_inc;
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign piece_valid  = r_valid;
    assign position_out = r_pos;
    assign piece_out    = r_piece;
    assign square_idx   = r_sqidx;
    assign busy         = r_busy;
    assign done         = r_done;
    assign piece_count  = r_count;
    assign code_err     = r_err;

endmodule
